fcims_order_ctrl: RTL
=====================

Name: fcims_order_ctrl

Overview:
Sequencing controller for the FCIMS price/stock datapath. It arbitrates round-robin between four order requesters and computes each order's total price (unit price x quantity) with a sequential shift-add multiplier. It then commits a sale or a restock to the stock-count register and reports the result. It holds the configurable unit-price register and the live stock count, so the combinational FCIMS datapath is replaced by a shared, one-order-at-a-time engine.

Parameters:
QW, 4, quantity and stock width in bits (stock max = 2^QW-1).
PW, 4, unit-price width in bits; total width = PW+QW.
STOCK_RST, 0, stock value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cfg_we  in  1  unit-price write strobe.
cfg_price  in  PW  new unit price.
req  in  4  per-requester order request (level, held until gnt).
op  in  4  per-requester op: 0 = sell, 1 = restock.
qty  in  4*QW  per-requester quantity; requester i uses bits [i*QW +: QW].
gnt  out  4  one-hot grant, one-cycle pulse.
busy  out  1  order in flight (state != IDLE).
done  out  1  one-cycle completion pulse.
done_id  out  2  index of the completed requester.
total  out  PW+QW  order total price; 0 on error.
err  out  1  order rejected (underflow or overflow).
stock  out  QW  current stock count.
price  out  PW  current unit-price register.

Behaviour:
- Reset asserted (low), including mid-order: state<=IDLE; gnt, busy, done, done_id, total, err <= 0; stock <= STOCK_RST; price <= 0; RR pointer <= 3. No partial commit, and no done is issued for an aborted order.
- States: IDLE, MUL, COMMIT.
- IDLE: on an edge with req != 0, pick the first set bit searching ptr+1, ptr+2, ... (mod 4), set gnt one-hot for the next cycle, ptr <= winner, and latch op, qty and a snapshot of price. Set acc <= 0, cnt <= 0, state <= MUL. req/op/qty are sampled only at this edge. A requester that drops req before gnt is not served.
- MUL: runs exactly QW cycles. On each cycle, if qty[cnt]=1 then acc += price_snap << cnt. cnt increments. After the cycle with cnt=QW-1, state <= COMMIT. acc is PW+QW bits wide and cannot overflow.
- COMMIT, sell: if qty <= stock then stock -= qty, total <= acc, err <= 0. Otherwise stock is unchanged, total <= 0, err <= 1.
- COMMIT, restock: if stock+qty <= 2^QW-1 (computed at QW+1 bits) then stock += qty, total <= acc, err <= 0. Otherwise stock is unchanged, total <= 0, err <= 1.
- qty=0 is legal: total 0, err 0, stock unchanged.
- COMMIT also sets done <= 1 (one cycle), done_id <= winner, and state <= IDLE.
- total, err and done_id hold their values until the next COMMIT.
- Latency: gnt is high in cycle G; done is high in cycle G+QW+1. The next grant can come at the earliest in cycle G+QW+2, which is the same cycle as done being high + 1.
- cfg_we updates price on any edge, including while busy. The in-flight order always uses its snapshot. If cfg_we and a grant occur on the same edge, the order uses the old price.
- Requests that arrive while busy wait; they are not queued internally.

Test Plan:
1. Reset, cfg price=8, req0 restock qty=12 -> gnt=0001 for one cycle, done 5 cycles later, done_id=0, total=96, err=0, stock=12.
2. Then req1 sell qty=3 -> total=24, stock=9, err=0, done_id=1.
3. Sell qty=10 at stock=9 -> err=1, total=0, stock=9. Then restock qty=7 -> err=1, stock=9. Then restock qty=6 -> stock=15, err=0.
4. price=15, restock qty=15 from stock 0 -> total=225. Then cfg_we price=3 during MUL -> that order still reports 225, and the next order uses 3.
5. After a grant to requester 1, hold req=1111 -> grants in order 2,3,0,1, one order per QW+2 cycles, and busy stays high except in the grant cycle boundaries.
6. Drive reset low during MUL of a sell qty=2 at stock=9 -> all outputs reach reset values immediately, stock=STOCK_RST, no done pulse. After release, a fresh req0 is granted first.

Source files
------------

// File: rtl/fcims_order_ctrl.sv
// FCIMS order sequencer: round-robin grant over four requesters, shift-add
// price x quantity, then a checked sale/restock commit to the stock register.
module fcims_order_ctrl #(
  parameter int unsigned QW        = 4,
  parameter int unsigned PW        = 4,
  parameter int unsigned STOCK_RST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PW-1:0]    cfg_price,
  input  logic [3:0]       req,
  input  logic [3:0]       op,
  input  logic [4*QW-1:0]  qty,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_id,
  output logic [PW+QW-1:0] total,
  output logic             err,
  output logic [QW-1:0]    stock,
  output logic [PW-1:0]    price
);

  localparam int unsigned TW = PW + QW;
  localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_COMMIT} state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_ptr, r_win;
  logic           r_op;
  logic [QW-1:0]  r_qty;
  logic [PW-1:0]  r_psnap;
  logic [TW-1:0]  r_acc;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_gnt;
  logic           r_done;
  logic [1:0]     r_done_id;
  logic [TW-1:0]  r_total;
  logic           r_err;
  logic [QW-1:0]  r_stock;
  logic [PW-1:0]  r_price;

  logic           w_found;
  logic [1:0]     w_win;
  logic           w_last;
  logic [TW-1:0]  w_addend;
  logic [QW:0]    w_sum;
  logic           w_ok;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_comb begin
    w_last   = (r_cnt == CW'(QW - 1));
    w_addend = r_qty[r_cnt] ? (TW'(r_psnap) << r_cnt) : '0;
    w_sum    = {1'b0, r_stock} + {1'b0, r_qty};
    w_ok     = r_op ? !w_sum[QW] : (r_qty <= r_stock);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_MUL;
      S_MUL:    if (w_last)  w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= 2'd3;
      r_win     <= '0;
      r_op      <= 1'b0;
      r_qty     <= '0;
      r_psnap   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_total   <= '0;
      r_err     <= 1'b0;
      r_stock   <= QW'(STOCK_RST);
      r_price   <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      if (cfg_we) r_price <= cfg_price;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= 4'b0001 << w_win;
            r_ptr   <= w_win;
            r_win   <= w_win;
            r_op    <= op[w_win];
            r_qty   <= qty[w_win*QW +: QW];
            r_psnap <= r_price;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_MUL: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + CW'(1);
        end
        S_COMMIT: begin
          r_done    <= 1'b1;
          r_done_id <= r_win;
          if (w_ok) begin
            r_total <= r_acc;
            r_err   <= 1'b0;
            r_stock <= r_op ? w_sum[QW-1:0] : (r_stock - r_qty);
          end else begin
            r_total <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign total   = r_total;
  assign err     = r_err;
  assign stock   = r_stock;
  assign price   = r_price;

endmodule
